hdb3_tx_sched: RTL and testbench

Round-robin scheduler that shares one serial HDB3 encoder between NUM_CH parallel-frame requesters.
- Grants one requester at a time, captures its FRAME_W-bit word and shifts it MSB-first into the encoder over a valid/ready bit interface.
- Pulses an encoder clear at each frame start so the polarity and zero-run state restart per frame.
- Inserts IDLE_GAP dead cycles between frames.

---
 rtl/hdb3_tx_sched.sv | 136 +++++++++++++
 tb/tb_hdb3_tx_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdb3_tx_sched.sv
// Round-robin scheduler feeding one serial HDB3 encoder from NUM_CH parallel-frame requesters.
// Frames are shifted MSB-first over a valid/ready bit link with sof/eof marks and a per-frame encoder clear.
module hdb3_tx_sched #(
    parameter int NUM_CH   = 4,
    parameter int FRAME_W  = 22,
    parameter int IDLE_GAP = 2
) (
    input  logic                                       sys_clk,
    input  logic                                       sys_rst_n,
    input  logic [NUM_CH-1:0]                          req,
    input  logic [NUM_CH*FRAME_W-1:0]                  data_i,
    output logic [NUM_CH-1:0]                          ack,
    output logic                                       enc_bit,
    output logic                                       enc_vld,
    input  logic                                       enc_rdy,
    output logic                                       enc_sof,
    output logic                                       enc_eof,
    output logic                                       enc_clr,
    output logic                                       busy,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cur_ch
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BC_W = $clog2(FRAME_W);
    localparam int GC_W = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;

    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(FRAME_W - 1);
    localparam logic [BC_W-1:0] PEN_BIT  = BC_W'(FRAME_W - 2);
    localparam logic [GC_W-1:0] LAST_GAP = GC_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    state_t             state;
    logic [CH_W-1:0]    rr_ptr;
    logic [CH_W-1:0]    grant;
    logic               found;
    int                 idx;
    logic [FRAME_W-1:0] sel_word;
    logic [FRAME_W-1:0] shreg;
    logic [BC_W-1:0]    bit_cnt;
    logic [GC_W-1:0]    gap_cnt;

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        grant = rr_ptr;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && req[CH_W'(idx)]) begin
                grant = CH_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb sel_word = data_i[int'(cur_ch)*FRAME_W +: FRAME_W];

    // shreg holds the bits still to come after the one currently on enc_bit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            cur_ch  <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            ack     <= '0;
            enc_bit <= 1'b0;
            enc_vld <= 1'b0;
            enc_sof <= 1'b0;
            enc_eof <= 1'b0;
            enc_clr <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ack     <= '0;
            enc_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        cur_ch     <= grant;
                        ack[grant] <= 1'b1;
                        enc_clr    <= 1'b1;
                        busy       <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    shreg   <= {sel_word[FRAME_W-2:0], 1'b0};
                    bit_cnt <= '0;
                    enc_vld <= 1'b1;
                    enc_bit <= sel_word[FRAME_W-1];
                    enc_sof <= 1'b1;
                    enc_eof <= 1'b0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (enc_rdy) begin
                        if (bit_cnt == LAST_BIT) begin
                            enc_vld <= 1'b0;
                            enc_bit <= 1'b0;
                            enc_sof <= 1'b0;
                            enc_eof <= 1'b0;
                            rr_ptr  <= (cur_ch == LAST_CH) ? '0 : cur_ch + 1'b1;
                            if (IDLE_GAP > 0) begin
                                gap_cnt <= '0;
                                state   <= GAP;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            shreg   <= {shreg[FRAME_W-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                            enc_bit <= shreg[FRAME_W-1];
                            enc_sof <= 1'b0;
                            enc_eof <= (bit_cnt == PEN_BIT);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == LAST_GAP) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hdb3_tx_sched.sv
// Bench for hdb3_tx_sched: directed scenarios plus randomized traffic against a cycle reference model,
// and a second instance with IDLE_GAP=0 for back-to-back framing.
module tb_hdb3_tx_sched;

    localparam int NUM_CH   = 4;
    localparam int FRAME_W  = 22;
    localparam int IDLE_GAP = 2;
    localparam int CH_W     = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        rst_n;
    logic [NUM_CH-1:0]           req;
    logic [NUM_CH*FRAME_W-1:0]   data;
    logic                        rdy;
    logic [NUM_CH-1:0]           ack;
    logic                        enc_bit, enc_vld, enc_sof, enc_eof, enc_clr, busy;
    logic [CH_W-1:0]             cur_ch;

    logic                        rst_b_n;
    logic [NUM_CH-1:0]           req_b;
    logic [NUM_CH*FRAME_W-1:0]   data_b;
    logic                        rdy_b;
    logic [NUM_CH-1:0]           ack_b;
    logic                        bit_b, vld_b, sof_b, eof_b, clr_b, busy_b;
    logic [CH_W-1:0]             cur_b;

    hdb3_tx_sched #(.NUM_CH(NUM_CH), .FRAME_W(FRAME_W), .IDLE_GAP(IDLE_GAP)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .req(req), .data_i(data), .ack(ack),
        .enc_bit(enc_bit), .enc_vld(enc_vld), .enc_rdy(rdy), .enc_sof(enc_sof),
        .enc_eof(enc_eof), .enc_clr(enc_clr), .busy(busy), .cur_ch(cur_ch)
    );

    hdb3_tx_sched #(.NUM_CH(NUM_CH), .FRAME_W(FRAME_W), .IDLE_GAP(0)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_b_n), .req(req_b), .data_i(data_b), .ack(ack_b),
        .enc_bit(bit_b), .enc_vld(vld_b), .enc_rdy(rdy_b), .enc_sof(sof_b),
        .enc_eof(eof_b), .enc_clr(clr_b), .busy(busy_b), .cur_ch(cur_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: frame index -1 means no bit on the link.
    bit                  m_busy, m_load;
    int                  m_idx, m_gap, m_ptr, m_cur;
    logic [FRAME_W-1:0]  m_frame;
    int                  grant_q[$];
    int                  xfers, eof_at;
    int                  drop_mode;

    int bcyc = 0, blow = 0;
    int sof_t[$];
    int low_q[$];

    always @(negedge clk) begin
        if (rst_b_n) begin
            bcyc++;
            if (sof_b) begin
                sof_t.push_back(bcyc);
                low_q.push_back(blow);
                blow = 0;
            end
            if (!vld_b) blow++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NUM_CH-1:0] r, input int ptr);
        for (int i = 0; i < NUM_CH; i++)
            if (r[(ptr + i) % NUM_CH]) return (ptr + i) % NUM_CH;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_load = 1'b0; m_idx = -1; m_gap = 0; m_ptr = 0; m_cur = 0;
        m_frame = '0;
    endtask

    task automatic cyc();
        logic [NUM_CH-1:0]         p_req;
        logic [NUM_CH*FRAME_W-1:0] p_data;
        logic                      p_rdy;
        logic [NUM_CH-1:0]         e_ack;
        logic                      e_clr, ev, eb, es, ee;
        int                        g;
        p_req  = req;
        p_data = data;
        p_rdy  = rdy;
        if (enc_vld && rdy) begin
            xfers++;
            if (enc_eof) eof_at = xfers;
        end
        @(posedge clk);
        #1;
        e_ack = '0;
        e_clr = 1'b0;
        if (!m_busy) begin
            if (p_req != '0) begin
                g = pick(p_req, m_ptr);
                e_ack = NUM_CH'(1) << g;
                e_clr = 1'b1;
                m_busy = 1'b1;
                m_load = 1'b1;
                m_cur = g;
                grant_q.push_back(g);
                xfers = 0;
                eof_at = 0;
            end
        end else if (m_load) begin
            m_load = 1'b0;
            m_frame = p_data[m_cur*FRAME_W +: FRAME_W];
            m_idx = 0;
        end else if (m_idx >= 0) begin
            if (p_rdy) begin
                if (m_idx == FRAME_W - 1) begin
                    m_idx = -1;
                    m_ptr = (m_cur + 1) % NUM_CH;
                    if (IDLE_GAP > 0) m_gap = IDLE_GAP;
                    else m_busy = 1'b0;
                end else begin
                    m_idx++;
                end
            end
        end else begin
            m_gap--;
            if (m_gap == 0) m_busy = 1'b0;
        end
        ev = (m_idx >= 0);
        eb = ev ? m_frame[FRAME_W-1-m_idx] : 1'b0;
        es = ev && (m_idx == 0);
        ee = ev && (m_idx == FRAME_W - 1);
        chk("cycle", {ack, enc_clr, enc_vld, enc_bit, enc_sof, enc_eof, busy, cur_ch},
                     {e_ack, e_clr, ev, eb, es, ee, m_busy, CH_W'(m_cur)});
        if (drop_mode == 1) req = req & ~ack;
        if (drop_mode == 2)
            for (int k = 0; k < NUM_CH; k++)
                if (ack[k] && $urandom_range(0, 3) != 0) req[k] = 1'b0;
    endtask

    task automatic run_until_idle(input int bound);
        int n;
        n = 0;
        while ((m_busy || req != '0) && n < bound) begin
            cyc();
            n++;
        end
        chk("idle_reached", (m_busy || req != '0), 1'b0);
    endtask

    initial begin
        logic [FRAME_W-1:0] bits_v, sof_v, eof_v, vld_v;
        logic               b0;
        int                 n;

        rst_n = 1'b0; rst_b_n = 1'b0;
        req = '0; data = '0; rdy = 1'b1;
        req_b = 4'b0010; data_b = '0; rdy_b = 1'b1;
        for (int k = 0; k < NUM_CH; k++) data_b[k*FRAME_W +: FRAME_W] = FRAME_W'($urandom);
        drop_mode = 1;
        xfers = 0; eof_at = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {ack, enc_clr, enc_vld, enc_bit, enc_sof, enc_eof, busy, cur_ch}, 0);
        rst_n = 1'b1; rst_b_n = 1'b1;
        cyc();
        cyc();

        // Single frame on channel 0, exact bit pattern.
        data[FRAME_W-1:0] = 22'b1000010000110000000011;
        req = 4'b0001;
        cyc();
        chk("t1_ack", ack, 4'b0001);
        chk("t1_clr", enc_clr, 1'b1);
        bits_v = '0; sof_v = '0; eof_v = '0; vld_v = '0;
        for (int i = 0; i < FRAME_W; i++) begin
            cyc();
            bits_v = {bits_v[FRAME_W-2:0], enc_bit};
            sof_v  = {sof_v[FRAME_W-2:0], enc_sof};
            eof_v  = {eof_v[FRAME_W-2:0], enc_eof};
            vld_v  = {vld_v[FRAME_W-2:0], enc_vld};
        end
        chk("t1_bits", bits_v, 22'b1000010000110000000011);
        chk("t1_sof", sof_v, 22'h200000);
        chk("t1_eof", eof_v, 22'h000001);
        chk("t1_vld", vld_v, 22'h3fffff);
        cyc();
        chk("t1_gap0_vld", enc_vld, 1'b0);
        cyc();
        chk("t1_gap1_vld", enc_vld, 1'b0);
        run_until_idle(50);

        // Pointer wrap: serve ch1 then offer ch0 and ch1 together.
        for (int k = 0; k < NUM_CH; k++) data[k*FRAME_W +: FRAME_W] = FRAME_W'($urandom);
        grant_q.delete();
        req = 4'b0010;
        run_until_idle(100);
        req = 4'b0011;
        run_until_idle(200);
        chk("ptr_wrap_cnt", grant_q.size(), 3);
        if (grant_q.size() == 3)
            chk("ptr_wrap_order", {8'(grant_q[0]), 8'(grant_q[1]), 8'(grant_q[2])}, 24'h010001);

        // Back-pressure on bit 5.
        req = 4'b0100;
        n = 0;
        while (m_idx != 4 && n < 50) begin cyc(); n++; end
        chk("stall_reach", m_idx, 4);
        b0 = enc_bit;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_bit", {enc_vld, enc_bit}, {1'b1, b0});
        end
        rdy = 1'b1;
        run_until_idle(100);
        chk("stall_xfers", xfers, FRAME_W);
        chk("stall_eof_at", eof_at, FRAME_W);

        // Asynchronous reset in the middle of a ch3 frame.
        req = 4'b1000;
        n = 0;
        while (m_idx != 9 && n < 50) begin cyc(); n++; end
        chk("rst_reach", m_idx, 9);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async", {ack, enc_clr, enc_vld, enc_bit, enc_sof, enc_eof, busy, cur_ch}, 0);
        model_reset();
        req = 4'b1100;
        @(posedge clk);
        #1;
        chk("rst_hold", {ack, enc_clr, enc_vld, enc_bit, enc_sof, enc_eof, busy, cur_ch}, 0);
        rst_n = 1'b1;
        grant_q.delete();
        cyc();
        chk("rst_grant_ack", ack, 4'b0100);
        chk("rst_grant_clr", enc_clr, 1'b1);
        chk("rst_grant_ch", cur_ch, 2'd2);
        run_until_idle(200);

        // All four requesting continuously.
        grant_q.delete();
        drop_mode = 0;
        req = 4'b1111;
        n = 0;
        while (grant_q.size() < 5 && n < 300) begin cyc(); n++; end
        req = '0;
        drop_mode = 1;
        run_until_idle(100);
        chk("rr_cnt", grant_q.size(), 5);
        if (grant_q.size() == 5)
            chk("rr_order", {8'(grant_q[0]), 8'(grant_q[1]), 8'(grant_q[2]), 8'(grant_q[3]), 8'(grant_q[4])},
                40'h0001020300);

        // Randomized traffic and back-pressure.
        drop_mode = 2;
        for (int c = 0; c < 2500; c++) begin
            rdy = ($urandom_range(0, 3) != 0);
            cyc();
            for (int k = 0; k < NUM_CH; k++)
                if (!req[k] && !ack[k] && $urandom_range(0, 5) == 0) begin
                    data[k*FRAME_W +: FRAME_W] = FRAME_W'($urandom);
                    req[k] = 1'b1;
                end
        end
        drop_mode = 1;
        rdy = 1'b1;
        run_until_idle(1000);

        // Zero-gap instance: back-to-back frames.
        chk("b_frames", sof_t.size() >= 4, 1'b1);
        for (int i = 1; i < sof_t.size() && i < 6; i++) begin
            chk("b_period", sof_t[i] - sof_t[i-1], FRAME_W + 2);
            chk("b_low_cycles", low_q[i], 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
